// File: rtl/trn_mem_pkg.sv
// Shared types and widths for the training-data RAM arbiter.
// Used by trn_mem_rr_arb and training_mem_arbiter.
package trn_mem_pkg;

  localparam int TRN_DATA_W = 33;
  localparam int TRN_ADDR_W = 8;

  // CLEAR is only reachable when TRN_MEM_CLEAR_EN is defined
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    CLEAR      = 3'd4
  } state_e;

  typedef enum logic {
    WRITER = 1'b0,
    READER = 1'b1
  } grant_e;

endpackage

// File: rtl/trn_mem_rr_arb.sv
// Two-way round-robin picker for the training RAM.
// req[0] = writer, req[1] = reader. grant is one-hot and purely
// combinational; last_grant only moves when the caller accepts the pick.
module trn_mem_rr_arb
  import trn_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  grant_e last_grant_q;
  grant_e last_grant_d;

  // Pick a winner: a lone requester wins, a tie goes to whoever did not win last
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_q == READER) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Record the winner only when the grant is actually taken
  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) begin
      if (grant[0]) begin
        last_grant_d = WRITER;
      end else if (grant[1]) begin
        last_grant_d = READER;
      end
    end
  end

  // last_grant register; READER after reset so the writer wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= READER;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/training_mem_arbiter.sv
// Sequencer/arbiter in front of the single-port training-data RAM.
// Shares the RAM between a sample writer and a training-engine reader,
// generates cs/we/oe/address, drives the shared bus only while writing and
// returns registered read data with a one-cycle valid strobe.
//
// Optional build macro: TRN_MEM_CLEAR_EN adds clr_start/clr_done and a
// CLEAR state that zero-fills the whole RAM.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | sample requests (and clr_start), latch the winner
// WRITE      | one-cycle RAM write, controller drives mem_data, wr_gnt high
// RD_ISSUE   | cs/oe high, RAM loads its output register, rd_gnt high
// RD_CAPTURE | RAM drives the bus, rd_data captured at the closing edge
// CLEAR      | zero-write one address per cycle, 0..RAM_DEPTH-1
module training_mem_arbiter
  import trn_mem_pkg::*;
#(
  parameter int DATA_WIDTH = TRN_DATA_W,
  parameter int ADDR_WIDTH = TRN_ADDR_W,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
`ifdef TRN_MEM_CLEAR_EN
  input  logic                  clr_start,
  output logic                  clr_done,
`endif
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  state_e state_q, state_d;

  // Address register sized from the RAM depth; it spans the RAM exactly,
  // so requester addresses are passed through with no wrap handling.
  logic [$clog2(RAM_DEPTH)-1:0] mem_address_q, mem_address_d;

  logic                  mem_cs_q,    mem_cs_d;
  logic                  mem_we_q,    mem_we_d;
  logic                  mem_oe_q,    mem_oe_d;
  logic                  wr_gnt_q,    wr_gnt_d;
  logic                  rd_gnt_q,    rd_gnt_d;
  logic                  rd_rvalid_q, rd_rvalid_d;
  logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
  logic                  busy_q,      busy_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;

`ifdef TRN_MEM_CLEAR_EN
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

  logic [ADDR_WIDTH:0]   clr_cnt_q,   clr_cnt_d;
  logic                  clr_done_q,  clr_done_d;
`endif

  logic [1:0]            arb_req;
  logic [1:0]            arb_grant;
  logic                  arb_advance;
  logic                  bus_drive;
  logic [DATA_WIDTH-1:0] bus_wdata;

  assign arb_req = {rd_req, wr_req};

  // The arbiter only commits its pick when IDLE actually hands out a grant;
  // a clear request pre-empts both requesters and leaves the rotation alone.
  always_comb begin
    arb_advance = (state_q == IDLE) && (arb_req != 2'b00);
`ifdef TRN_MEM_CLEAR_EN
    if (clr_start) begin
      arb_advance = 1'b0;
    end
`endif
  end

  trn_mem_rr_arb u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  // Next-state and next-output decode; outputs are registered so the
  // values computed here appear in the cycle the FSM enters the new state.
  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    mem_cs_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_oe_d      = 1'b0;
    wr_gnt_d      = 1'b0;
    rd_gnt_d      = 1'b0;
    rd_rvalid_d   = 1'b0;
    rd_data_d     = rd_data_q;
    wdata_d       = wdata_q;
`ifdef TRN_MEM_CLEAR_EN
    clr_cnt_d     = clr_cnt_q;
    clr_done_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
`ifdef TRN_MEM_CLEAR_EN
        if (clr_start) begin
          state_d       = CLEAR;
          clr_cnt_d     = '0;
          mem_address_d = '0;
          mem_cs_d      = 1'b1;
          mem_we_d      = 1'b1;
        end else
`endif
        if (arb_grant[0]) begin
          state_d       = WRITE;
          mem_address_d = wr_addr;
          wdata_d       = wr_data;
          mem_cs_d      = 1'b1;
          mem_we_d      = 1'b1;
          wr_gnt_d      = 1'b1;
        end else if (arb_grant[1]) begin
          state_d       = RD_ISSUE;
          mem_address_d = rd_addr;
          mem_cs_d      = 1'b1;
          mem_oe_d      = 1'b1;
          rd_gnt_d      = 1'b1;
        end
      end

      // Always back through IDLE so a read never follows a driven bus cycle
      WRITE: begin
        state_d = IDLE;
      end

      RD_ISSUE: begin
        state_d  = RD_CAPTURE;
        mem_cs_d = 1'b1;
        mem_oe_d = 1'b1;
      end

      RD_CAPTURE: begin
        state_d     = IDLE;
        rd_data_d   = mem_data;
        rd_rvalid_d = 1'b1;
      end

`ifdef TRN_MEM_CLEAR_EN
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d     = clr_cnt_q + 1'b1;
          mem_address_d = clr_cnt_d[ADDR_WIDTH-1:0];
          mem_cs_d      = 1'b1;
          mem_we_d      = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Bus enable is decoded from the current state rather than registered,
  // so it tracks exactly the cycles in which we is high.
  always_comb begin
    bus_drive = (state_q == WRITE);
    bus_wdata = wdata_q;
`ifdef TRN_MEM_CLEAR_EN
    if (state_q == CLEAR) begin
      bus_drive = 1'b1;
      bus_wdata = '0;
    end
`endif
  end

  assign mem_data = bus_drive ? bus_wdata : {DATA_WIDTH{1'bz}};

  // State and output registers; reset returns to IDLE at once and drops any
  // in-flight strobe (a write on the reset edge still lands at the RAM).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_address_q <= '0;
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_oe_q      <= 1'b0;
      wr_gnt_q      <= 1'b0;
      rd_gnt_q      <= 1'b0;
      rd_rvalid_q   <= 1'b0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
      wdata_q       <= '0;
`ifdef TRN_MEM_CLEAR_EN
      clr_cnt_q     <= '0;
      clr_done_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_cs_q      <= mem_cs_d;
      mem_we_q      <= mem_we_d;
      mem_oe_q      <= mem_oe_d;
      wr_gnt_q      <= wr_gnt_d;
      rd_gnt_q      <= rd_gnt_d;
      rd_rvalid_q   <= rd_rvalid_d;
      rd_data_q     <= rd_data_d;
      busy_q        <= busy_d;
      wdata_q       <= wdata_d;
`ifdef TRN_MEM_CLEAR_EN
      clr_cnt_q     <= clr_cnt_d;
      clr_done_q    <= clr_done_d;
`endif
    end
  end

  assign mem_address = mem_address_q;
  assign mem_cs      = mem_cs_q;
  assign mem_we      = mem_we_q;
  assign mem_oe      = mem_oe_q;
  assign wr_gnt      = wr_gnt_q;
  assign rd_gnt      = rd_gnt_q;
  assign rd_rvalid   = rd_rvalid_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
`ifdef TRN_MEM_CLEAR_EN
  assign clr_done    = clr_done_q;
`endif

endmodule

// File: tb/tb_training_mem_arbiter.sv
// Bench for training_mem_arbiter with a behavioural single-port RAM
// (registered read, drives the bus only while cs & oe & !we).
// Build with TRN_MEM_CLEAR_EN defined to also exercise the clear sequence.
module tb_training_mem_arbiter;

  localparam int DW = 33;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt;
  logic          rd_rvalid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic [AW-1:0] mem_address;
  logic          mem_cs;
  logic          mem_we;
  logic          mem_oe;
  wire  [DW-1:0] mem_data;
`ifdef TRN_MEM_CLEAR_EN
  logic          clr_start = 1'b0;
  logic          clr_done;
`endif

  int total = 0;
  int bad   = 0;
  int contention = 0;

  always #5 clk = ~clk;

  training_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_rvalid   (rd_rvalid),
    .rd_data     (rd_data),
    .busy        (busy),
    .mem_address (mem_address),
    .mem_cs      (mem_cs),
    .mem_we      (mem_we),
    .mem_oe      (mem_oe),
`ifdef TRN_MEM_CLEAR_EN
    .clr_start   (clr_start),
    .clr_done    (clr_done),
`endif
    .mem_data    (mem_data)
  );

  // RAM model
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] ram_q = '0;
  logic          ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      ram_init <= 1'b1;
    end else begin
      if (mem_cs && mem_we) ram[mem_address] <= mem_data;
      if (mem_cs && !mem_we) ram_q <= ram[mem_address];
    end
  end

  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : {DW{1'bz}};

  always @(negedge clk) begin
    if (mem_oe && mem_we) contention++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts at a negedge in an IDLE cycle (cycle 0), ends at a negedge in IDLE
  task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    step();
    check({tag, "_wr_gnt_c1"}, wr_gnt, 1);
    check({tag, "_cs_we_oe_c1"}, {mem_cs, mem_we, mem_oe}, 3'b110);
    check({tag, "_addr_c1"}, mem_address, a);
    check({tag, "_bus_c1"}, mem_data, d);
    check({tag, "_busy_c1"}, busy, 1);
    wr_req = 1'b0;
    step();
    check({tag, "_gnt_busy_c2"}, {wr_gnt, busy, mem_cs}, 3'b000);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_addr = a; rd_req = 1'b1;
    step();
    check({tag, "_rd_gnt_c1"}, {rd_gnt, rd_rvalid}, 2'b10);
    check({tag, "_cs_we_oe_c1"}, {mem_cs, mem_we, mem_oe}, 3'b101);
    check({tag, "_addr_c1"}, mem_address, a);
    rd_req = 1'b0;
    step();
    check({tag, "_c2"}, {rd_gnt, rd_rvalid, mem_cs, mem_we, mem_oe}, 5'b00101);
    step();
    check({tag, "_rvalid_c3"}, {rd_rvalid, busy, mem_oe}, 3'b100);
    check({tag, "_rd_data_c3"}, rd_data, exp);
    step();
    check({tag, "_rvalid_c4"}, rd_rvalid, 0);
    check({tag, "_rd_hold_c4"}, rd_data, exp);
  endtask

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [11:0] wh, rh, vh;
    vecs[0] = '{1'b1, 8'h05, 33'h1_2345_6789};
    vecs[1] = '{1'b0, 8'h05, 33'h1_2345_6789};
    vecs[2] = '{1'b1, 8'hFF, 33'h1_FFFF_FFFF};
    vecs[3] = '{1'b0, 8'hFF, 33'h1_FFFF_FFFF};
    vecs[4] = '{1'b0, 8'h00, 33'h0_0000_0000};
    vecs[5] = '{1'b1, 8'h00, 33'h0_AAAA_5555};
    vecs[6] = '{1'b0, 8'h00, 33'h0_AAAA_5555};
    vecs[7] = '{1'b0, 8'hFF, 33'h1_FFFF_FFFF};
    vecs[8] = '{1'b1, 8'h80, 33'h0_0000_0001};
    vecs[9] = '{1'b0, 8'h80, 33'h0_0000_0001};

    do_reset();
    check("reset_ctrl", {wr_gnt, rd_gnt, rd_rvalid, busy, mem_cs, mem_we, mem_oe}, 7'b0);
    check("reset_addr", mem_address, 0);
    check("reset_rd_data", rd_data, 0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) do_write($sformatf("v%0d", i), vecs[i].addr, vecs[i].data);
      else               do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].data);
    end

    // Reset on the WRITE edge: grant strobe cleared, RAM still takes the word
    wr_addr = 8'h33; wr_data = 33'h1_0000_0033; wr_req = 1'b1;
    step();
    check("rstw_wr_gnt_c1", wr_gnt, 1);
    wr_req = 1'b0; rst = 1'b1;
    step();
    check("rstw_after", {wr_gnt, busy, mem_cs, mem_we}, 4'b0000);
    rst = 1'b0;
    do_read("rstw_rd", 8'h33, 33'h1_0000_0033);

    // Reset during RD_CAPTURE: no rvalid, everything back to reset values
    rd_addr = 8'h05; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    check("rstr_in_capture", {mem_oe, mem_we}, 2'b10);
    rst = 1'b1;
    step();
    check("rstr_ctrl", {rd_rvalid, busy, mem_cs, mem_we, mem_oe}, 5'b0);
    check("rstr_addr", mem_address, 0);
    check("rstr_rd_data", rd_data, 0);
    rst = 1'b0;
    step();
    check("rstr_no_late_rvalid", rd_rvalid, 0);

    // Continuous dual requests from a fresh reset: W,R,W,R with writer first
    wr_addr = 8'h10; wr_data = 33'h0_1111_2222; wr_req = 1'b1;
    rd_addr = 8'h05; rd_req = 1'b1;
    wh = '0; rh = '0; vh = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      wh[c-1] = wr_gnt;
      rh[c-1] = rd_gnt;
      vh[c-1] = rd_rvalid;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("dual_wr_gnt_cycles", wh, 12'h421);
    check("dual_rd_gnt_cycles", rh, 12'h084);
    check("dual_rvalid_cycles", vh, 12'h210);
    check("dual_rd_data", rd_data, 33'h1_2345_6789);
    step();
    do_read("dual_wr_landed", 8'h10, 33'h0_1111_2222);

`ifdef TRN_MEM_CLEAR_EN
    begin
      int done_cyc;
      int gnt_cyc;
      int busy_drop;
      done_cyc = -1; gnt_cyc = -1; busy_drop = 0;
      wr_addr = 8'h40; wr_data = 33'h0_0000_0005; wr_req = 1'b1; clr_start = 1'b1;
      step();
      check("clr_first", {mem_cs, mem_we, mem_oe, wr_gnt, busy}, 5'b11001);
      check("clr_first_addr", mem_address, 0);
      check("clr_first_bus", mem_data, 0);
      clr_start = 1'b0;
      for (int c = 2; c <= 400 && gnt_cyc < 0; c++) begin
        if (c == 100) clr_start = 1'b1;
        if (c == 101) clr_start = 1'b0;
        step();
        if (clr_done && done_cyc < 0) done_cyc = c;
        if (wr_gnt && gnt_cyc < 0) begin
          gnt_cyc = c;
          wr_req = 1'b0;
        end
        if (c <= 256 && !busy) busy_drop++;
      end
      wr_req = 1'b0;
      check("clr_done_cycle", done_cyc, 257);
      check("clr_pending_wr_gnt_cycle", gnt_cyc, 258);
      check("clr_busy_gaps", busy_drop, 0);
      step();
      do_read("clr_rd_80", 8'h80, 33'h0);
      do_read("clr_rd_40", 8'h40, 33'h0_0000_0005);
      do_read("clr_rd_ff", 8'hFF, 33'h0);
    end
`endif

    check("bus_contention_events", contention, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
